// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int FETCH_DEPTH = 2;
    localparam int CREDIT_W = $clog2(FETCH_DEPTH + 1);
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response channel between fetch and memory.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int DW = XLEN
) ();
    logic          ImemReqValid;
    logic          ImemReqReady;
    logic [DW-1:0] ImemReqAddr;
    logic          ImemRspValid;
    logic [DW-1:0] ImemRspData;
    modport master (output ImemReqValid, ImemReqAddr, input ImemReqReady, ImemRspValid, ImemRspData);
    modport slave (input ImemReqValid, ImemReqAddr, output ImemReqReady, ImemRspValid, ImemRspData);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous prefetch FIFO of {instr, pc}; clear wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    input  logic         i_clear,
    output logic         o_full,
    output logic         o_empty,
    output logic [CW-1:0] o_count,
    output fetch_entry_t o_head
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    always_ff @(posedge clk)
        if (w_push && !i_clear) r_mem[r_wr] <= i_data;
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= bump(r_wr);
            if (w_pop) r_rd <= bump(r_rd);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage with credit-limited prefetch, redirect squash and IF/ID register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH = FETCH_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_if.master               imem,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  StallD,
    input  logic                  FlushD,
    output logic [DATA_WIDTH-1:0] instrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  InstrValidD
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [DATA_WIDTH-1:0] r_pcf, r_exp_pc, r_instr, r_pcd, r_pcp4;
    logic                  r_valid;
    logic [CW-1:0]         r_o, r_d, w_count;
    logic [CW:0]           w_used;
    logic                  w_full, w_empty, w_req, w_acc, w_rsp, w_stale, w_push, w_pop, w_bubble;
    fetch_entry_t          w_head, w_entry;
    assign w_used   = {1'b0, r_o} + {1'b0, w_count};
    assign w_req    = !rst && !PCSrcE && (w_used < (CW + 1)'(FIFO_DEPTH));
    assign w_acc    = w_req && imem.ImemReqReady;
    assign w_rsp    = imem.ImemRspValid;
    assign w_stale  = r_d != '0;
    assign w_push   = w_rsp && !w_stale && !PCSrcE;
    assign w_bubble = PCSrcE || FlushD;
    assign w_pop    = !w_bubble && !StallD && !w_empty;
    assign w_entry  = '{instr: imem.ImemRspData, pc: r_exp_pc};
    assign imem.ImemReqValid = w_req;
    assign imem.ImemReqAddr  = r_pcf;
    assign instrD      = r_instr;
    assign PCD         = r_pcd;
    assign PCPlus4D    = r_pcp4;
    assign InstrValidD = r_valid;
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk(clk), .rst(rst), .i_push(w_push), .i_data(w_entry), .i_pop(w_pop),
        .i_clear(PCSrcE), .o_full(w_full), .o_empty(w_empty), .o_count(w_count), .o_head(w_head)
    );
    // A redirect turns every in-flight response stale, including one arriving this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcf    <= RESET_PC;
            r_exp_pc <= RESET_PC;
            r_o      <= '0;
            r_d      <= '0;
            r_instr  <= NOP_INSTR;
            r_pcd    <= '0;
            r_pcp4   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_o      <= r_o + CW'(w_acc) - CW'(w_rsp);
            r_d      <= PCSrcE ? r_o - CW'(w_rsp) : r_d - CW'(w_rsp && w_stale);
            r_pcf    <= PCSrcE ? PCTargetE : w_acc ? r_pcf + DATA_WIDTH'(4) : r_pcf;
            r_exp_pc <= PCSrcE ? PCTargetE : w_push ? r_exp_pc + DATA_WIDTH'(4) : r_exp_pc;
            if (w_bubble || (!StallD && w_empty)) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else if (w_pop) begin
                r_instr <= w_head.instr;
                r_pcd   <= w_head.pc;
                r_pcp4  <= w_head.pc + DATA_WIDTH'(4);
                r_valid <= 1'b1;
            end
        end
    end
    always_ff @(posedge clk)
        if (!rst) assert (!(w_push && w_full));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against an in-order imem model with variable latency.
module tb_fetch_unit;
    import fetch_pkg::*;
    logic        clk = 0, rst = 1, PCSrcE = 0, StallD = 0, FlushD = 0, InstrValidD;
    logic [31:0] PCTargetE = 0, instrD, PCD, PCPlus4D;
    int          n_checks = 0, n_pass = 0, lat = 1, cyc = 0;
    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t q[$];
    fetch_if #(.DW(32)) bus ();
    fetch_unit dut (
        .clk(clk), .rst(rst), .imem(bus), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallD(StallD), .FlushD(FlushD), .instrD(instrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .InstrValidD(InstrValidD)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 0 ? 32'h0050_0093 : {a[19:0], 12'h013};
    endfunction
    always @(negedge clk)
        if (rst) q.delete();
        else if (bus.ImemReqValid && bus.ImemReqReady) q.push_back('{bus.ImemReqAddr, cyc + lat});
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due <= cyc) begin
            bus.ImemRspValid = 1'b1;
            bus.ImemRspData  = mem_word(q[0].addr);
            void'(q.pop_front());
        end else begin
            bus.ImemRspValid = 1'b0;
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic do_reset();
        rst = 1; StallD = 0; FlushD = 0; PCSrcE = 0; bus.ImemReqReady = 1; lat = 1;
        tick();
        rst = 0;
    endtask
    initial begin
        bus.ImemReqReady = 1;
        tick(); tick(); #1;
        check("rst_instr", instrD, 32'h13);
        check("rst_pcd", PCD, 0);
        check("rst_pcp4", PCPlus4D, 0);
        check("rst_valid", InstrValidD, 0);
        check("rst_reqv", bus.ImemReqValid, 0);
        check("rst_addr", bus.ImemReqAddr, 0);
        // basic stream
        do_reset(); #1;
        check("bs_req0", bus.ImemReqValid, 1);
        check("bs_addr0", bus.ImemReqAddr, 0);
        tick(); #1;
        check("bs_addr4", bus.ImemReqAddr, 4);
        tick(); #1;
        check("bs_credit", bus.ImemReqValid, 0);
        tick(); #1;
        check("bs_instr0", instrD, 32'h0050_0093);
        check("bs_pcd0", PCD, 0);
        check("bs_pcp4", PCPlus4D, 4);
        check("bs_valid0", InstrValidD, 1);
        check("bs_addr8", bus.ImemReqAddr, 8);
        tick(); #1;
        check("bs_pcd4", PCD, 4);
        check("bs_instr4", instrD, 32'h0000_4013);
        tick(); #1;
        check("bs_bubble", InstrValidD, 0);
        check("bs_nop", instrD, 32'h13);
        tick(); #1;
        check("bs_pcd8", PCD, 8);
        check("bs_valid8", InstrValidD, 1);
        // decode flush: squashes IF/ID without popping the FIFO
        do_reset(); tick(); tick(); tick();
        FlushD = 1; #1;
        check("fl_pre", InstrValidD, 1);
        tick(); FlushD = 0; #1;
        check("fl_valid", InstrValidD, 0);
        check("fl_nop", instrD, 32'h13);
        check("fl_pcd_keep", PCD, 0);
        tick(); #1;
        check("fl_pcd4", PCD, 4);
        check("fl_instr4", instrD, 32'h0000_4013);
        check("fl_valid4", InstrValidD, 1);
        // decode stall for 4 cycles
        do_reset(); tick(); tick(); tick();
        StallD = 1; #1;
        check("st_pcd_a", PCD, 0);
        tick(); #1;
        check("st_instr_b", instrD, 32'h0050_0093);
        check("st_valid_b", InstrValidD, 1);
        tick(); #1;
        check("st_noreq", bus.ImemReqValid, 0);
        check("st_pcd_c", PCD, 0);
        tick(); #1;
        check("st_pcd_d", PCD, 0);
        check("st_valid_d", InstrValidD, 1);
        tick(); StallD = 0; #1;
        check("st_pcd_e", PCD, 0);
        tick(); #1;
        check("st_pcd4", PCD, 4);
        check("st_valid4", InstrValidD, 1);
        tick(); #1;
        check("st_pcd8", PCD, 8);
        check("st_instr8", instrD, 32'h0000_8013);
        // redirect with two in flight, latency 3
        do_reset(); lat = 3; tick(); tick();
        PCSrcE = 1; PCTargetE = 32'h100; #1;
        check("rd_noreq", bus.ImemReqValid, 0);
        tick(); PCSrcE = 0; #1;
        check("rd_pcf", bus.ImemReqAddr, 32'h100);
        check("rd_valid_a", InstrValidD, 0);
        tick(); #1;
        check("rd_req", bus.ImemReqValid, 1);
        check("rd_addr", bus.ImemReqAddr, 32'h100);
        tick(); tick(); #1;
        check("rd_valid_b", InstrValidD, 0);
        check("rd_nop_b", instrD, 32'h13);
        tick(); tick(); #1;
        check("rd_valid_c", InstrValidD, 0);
        tick(); #1;
        check("rd_instr", instrD, 32'h0010_0013);
        check("rd_pcd", PCD, 32'h100);
        check("rd_pcp4", PCPlus4D, 32'h104);
        check("rd_valid", InstrValidD, 1);
        // memory backpressure for 5 cycles
        do_reset(); tick(); tick(); tick();
        bus.ImemReqReady = 0; #1;
        check("bp_addr_a", bus.ImemReqAddr, 8);
        tick(); #1;
        check("bp_pcd4", PCD, 4);
        tick(); #1;
        check("bp_bubble", InstrValidD, 0);
        check("bp_nop", instrD, 32'h13);
        check("bp_addr_b", bus.ImemReqAddr, 8);
        tick(); tick(); #1;
        check("bp_addr_c", bus.ImemReqAddr, 8);
        check("bp_reqv", bus.ImemReqValid, 1);
        tick(); bus.ImemReqReady = 1;
        tick(); #1;
        check("bp_addr12", bus.ImemReqAddr, 12);
        tick(); tick(); #1;
        check("bp_pcd8", PCD, 8);
        check("bp_instr8", instrD, 32'h0000_8013);
        check("bp_valid8", InstrValidD, 1);
        // redirect, stall and response in the same cycle
        do_reset(); tick(); tick(); tick(); tick();
        PCSrcE = 1; StallD = 1; PCTargetE = 32'h200; #1;
        check("sm_noreq", bus.ImemReqValid, 0);
        tick(); PCSrcE = 0; StallD = 0; #1;
        check("sm_nop", instrD, 32'h13);
        check("sm_valid", InstrValidD, 0);
        check("sm_pcd_keep", PCD, 4);
        check("sm_pcp4_keep", PCPlus4D, 8);
        check("sm_pcf", bus.ImemReqAddr, 32'h200);
        tick(); #1;
        check("sm_empty", InstrValidD, 0);
        tick(); tick(); #1;
        check("sm_pcd", PCD, 32'h200);
        check("sm_instr", instrD, 32'h0020_0013);
        // PC wrap-around
        do_reset();
        PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC; #1;
        check("wr_noreq", bus.ImemReqValid, 0);
        tick(); PCSrcE = 0; #1;
        check("wr_addr", bus.ImemReqAddr, 32'hFFFF_FFFC);
        tick(); #1;
        check("wr_addr0", bus.ImemReqAddr, 0);
        tick(); tick(); #1;
        check("wr_pcd", PCD, 32'hFFFF_FFFC);
        check("wr_pcp4", PCPlus4D, 0);
        check("wr_instr", instrD, 32'hFFFF_C013);
        // reset mid-stream with one in flight and one buffered
        do_reset(); tick(); tick(); tick();
        StallD = 1;
        tick(); rst = 1; StallD = 0; #1;
        check("mr_reqv", bus.ImemReqValid, 0);
        check("mr_pre", InstrValidD, 1);
        tick(); rst = 0; #1;
        check("mr_instr", instrD, 32'h13);
        check("mr_pcd", PCD, 0);
        check("mr_pcp4", PCPlus4D, 0);
        check("mr_valid", InstrValidD, 0);
        check("mr_addr", bus.ImemReqAddr, 0);
        check("mr_req", bus.ImemReqValid, 1);
        tick(); tick(); tick(); #1;
        check("mr_instr0", instrD, 32'h0050_0093);
        check("mr_valid0", InstrValidD, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
